// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Purpose: EX-operand forwarding select across NUM_FWD later stages, with the
// youngest stage winning. Also covers load-use hazard detection, a register
// scoreboard for in-flight multi-cycle (div/mul) writebacks, the ID stall /
// EX bubble outputs, and a sticky stall watchdog.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds three 32-bit performance
// counters (perf_lu_stalls_o, perf_sb_stalls_o, perf_fwd_events_o).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid_i          valid instruction in ID
//   id_rs_addr_i        ID source addresses (NUM_SRC x AW)
//   id_rs_used_i        per-source "actually read" flags
//   id_rd_addr_i        ID destination
//   id_mc_issue_i       ID is a multi-cycle op writing id_rd_addr_i
//   ex_rs_addr_i        EX source addresses (NUM_SRC x AW)
//   ex_rd_addr_i        EX destination
//   ex_reg_write_i      EX writes a register
//   ex_is_load_i        EX is a load
//   fwd_rd_addr_i       destination per later stage (index 0 = youngest)
//   fwd_reg_write_i     RegWrite per later stage
//   fwd_data_i          result per later stage
//   mc_wb_valid_i       multi-cycle unit writes back this cycle
//   mc_wb_rd_addr_i     multi-cycle writeback destination
//   fwd_sel_o           per source: 0 = register file, k+1 = stage k
//   fwd_val_o           per source forwarded data, 0 when select is 0
//   stall_id_o          hold PC and IF/ID
//   bubble_ex_o         insert a NOP into ID/EX at the next edge
//   sb_busy_o           scoreboard busy bits
//   stall_timeout_o     sticky watchdog flag
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int NUM_FWD   = 2,
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int STALL_MAX = 15,
  parameter int SELW      = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*AW-1:0]     id_rs_addr_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [AW-1:0]             id_rd_addr_i,
  input  logic                      id_mc_issue_i,
  input  logic [NUM_SRC*AW-1:0]     ex_rs_addr_i,
  input  logic [AW-1:0]             ex_rd_addr_i,
  input  logic                      ex_reg_write_i,
  input  logic                      ex_is_load_i,
  input  logic [NUM_FWD*AW-1:0]     fwd_rd_addr_i,
  input  logic [NUM_FWD-1:0]        fwd_reg_write_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  input  logic                      mc_wb_valid_i,
  input  logic [AW-1:0]             mc_wb_rd_addr_i,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
  output logic [NUM_SRC*XLEN-1:0]   fwd_val_o,
  output logic                      stall_id_o,
  output logic                      bubble_ex_o,
  output logic [NREG-1:0]           sb_busy_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]               perf_lu_stalls_o,
  output logic [31:0]               perf_sb_stalls_o,
  output logic [31:0]               perf_fwd_events_o,
`endif
  output logic                      stall_timeout_o
);

  localparam int CW = $clog2(STALL_MAX + 1);

  logic [NREG-1:0] sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            lu, sb, stall;

  // ---------------------------------------------------------------------------
  // Forwarding: scan oldest to youngest so the youngest match is written last
  // and therefore wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    fwd_sel_o = '0;
    fwd_val_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_reg_write_i[k] &&
            (fwd_rd_addr_i[k*AW +: AW] != '0) &&
            (fwd_rd_addr_i[k*AW +: AW] == ex_rs_addr_i[s*AW +: AW])) begin
          fwd_sel_o[s*SELW +: SELW] = SELW'(k + 1);
          fwd_val_o[s*XLEN +: XLEN] = fwd_data_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection. The scoreboard term uses the registered busy bits, so a
  // writeback clearing a bit this cycle still stalls until the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    lu = 1'b0;
    sb = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used_i[s]) begin
        if (ex_is_load_i && ex_reg_write_i && (ex_rd_addr_i != '0) &&
            (id_rs_addr_i[s*AW +: AW] == ex_rd_addr_i))
          lu = 1'b1;
        if (sb_q[id_rs_addr_i[s*AW +: AW]])
          sb = 1'b1;
      end
    end
    // Destination still owned by an in-flight multi-cycle op (WAW).
    if (sb_q[id_rd_addr_i])
      sb = 1'b1;
    lu = lu & id_valid_i;
    sb = sb & id_valid_i;
  end

  assign stall       = lu | sb;
  assign stall_id_o  = stall;
  assign bubble_ex_o = stall;

  // ---------------------------------------------------------------------------
  // Scoreboard next state: clear first, then set, so a same-cycle set wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    sb_d = sb_q;
    if (mc_wb_valid_i)
      sb_d[mc_wb_rd_addr_i] = 1'b0;
    if (id_valid_i && id_mc_issue_i && !stall && (id_rd_addr_i != '0))
      sb_d[id_rd_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Stall watchdog: saturating consecutive-stall counter plus sticky flag.
  always_comb begin
    cnt_d = '0;
    if (stall)
      cnt_d = (cnt_q == CW'(STALL_MAX)) ? cnt_q : cnt_q + 1'b1;
    timeout_d = timeout_q | (cnt_d == CW'(STALL_MAX));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sb_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign sb_busy_o       = sb_q;
  assign stall_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_sb_q, perf_fwd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q  <= '0;
      perf_sb_q  <= '0;
      perf_fwd_q <= '0;
    end else begin
      if (lu)
        perf_lu_q <= perf_lu_q + 32'd1;
      if (sb && !lu)
        perf_sb_q <= perf_sb_q + 32'd1;
      if (|fwd_sel_o)
        perf_fwd_q <= perf_fwd_q + 32'd1;
    end
  end

  assign perf_lu_stalls_o  = perf_lu_q;
  assign perf_sb_stalls_o  = perf_sb_q;
  assign perf_fwd_events_o = perf_fwd_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
//
// Directed bench: a table of combinational forwarding / load-use vectors,
// followed by hand-written multi-cycle sequences for the scoreboard, the
// same-cycle set/clear case, the stall watchdog and reset mid-operation.
// Inputs change 1 ns after a rising edge; outputs are compared on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int SELW    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    id_valid;
  logic [NUM_SRC*AW-1:0]   id_rs_addr;
  logic [NUM_SRC-1:0]      id_rs_used;
  logic [AW-1:0]           id_rd_addr;
  logic                    id_mc_issue;
  logic [NUM_SRC*AW-1:0]   ex_rs_addr;
  logic [AW-1:0]           ex_rd_addr;
  logic                    ex_reg_write;
  logic                    ex_is_load;
  logic [NUM_FWD*AW-1:0]   fwd_rd_addr;
  logic [NUM_FWD-1:0]      fwd_reg_write;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    mc_wb_valid;
  logic [AW-1:0]           mc_wb_rd_addr;
  logic [NUM_SRC*SELW-1:0] fwd_sel;
  logic [NUM_SRC*XLEN-1:0] fwd_val;
  logic                    stall_id;
  logic                    bubble_ex;
  logic [NREG-1:0]         sb_busy;
  logic                    stall_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]             perf_lu_stalls;
  logic [31:0]             perf_sb_stalls;
  logic [31:0]             perf_fwd_events;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid_i      (id_valid),
    .id_rs_addr_i    (id_rs_addr),
    .id_rs_used_i    (id_rs_used),
    .id_rd_addr_i    (id_rd_addr),
    .id_mc_issue_i   (id_mc_issue),
    .ex_rs_addr_i    (ex_rs_addr),
    .ex_rd_addr_i    (ex_rd_addr),
    .ex_reg_write_i  (ex_reg_write),
    .ex_is_load_i    (ex_is_load),
    .fwd_rd_addr_i   (fwd_rd_addr),
    .fwd_reg_write_i (fwd_reg_write),
    .fwd_data_i      (fwd_data),
    .mc_wb_valid_i   (mc_wb_valid),
    .mc_wb_rd_addr_i (mc_wb_rd_addr),
    .fwd_sel_o       (fwd_sel),
    .fwd_val_o       (fwd_val),
    .stall_id_o      (stall_id),
    .bubble_ex_o     (bubble_ex),
    .sb_busy_o       (sb_busy),
`ifdef HAZARD_PERF_CNT_EN
    .perf_lu_stalls_o  (perf_lu_stalls),
    .perf_sb_stalls_o  (perf_sb_stalls),
    .perf_fwd_events_o (perf_fwd_events),
`endif
    .stall_timeout_o (stall_timeout)
  );

  typedef struct {
    string                   name;
    logic [NUM_SRC*AW-1:0]   ex_rs;
    logic [NUM_FWD*AW-1:0]   f_rd;
    logic [NUM_FWD-1:0]      f_rw;
    logic [NUM_FWD*XLEN-1:0] f_data;
    logic                    idv;
    logic [NUM_SRC*AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]      used;
    logic [AW-1:0]           ex_rd;
    logic                    ex_rw;
    logic                    ex_ld;
    logic [NUM_SRC*SELW-1:0] exp_sel;
    logic [NUM_SRC*XLEN-1:0] exp_val;
    logic                    exp_stall;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_valid      = 1'b0;
    id_rs_addr    = '0;
    id_rs_used    = '0;
    id_rd_addr    = '0;
    id_mc_issue   = 1'b0;
    ex_rs_addr    = '0;
    ex_rd_addr    = '0;
    ex_reg_write  = 1'b0;
    ex_is_load    = 1'b0;
    fwd_rd_addr   = '0;
    fwd_reg_write = '0;
    fwd_data      = '0;
    mc_wb_valid   = 1'b0;
    mc_wb_rd_addr = '0;
  endtask

  initial begin
    // Fields: name, ex_rs{s1,s0}, fwd_rd{k1,k0}, fwd_rw, fwd_data{k1,k0},
    //         id_valid, id_rs{s1,s0}, used, ex_rd, ex_rw, ex_ld,
    //         exp_sel{s1,s0}, exp_val{s1,s0}, exp_stall
    vecs[0]  = '{"fwd_priority", {5'd0, 5'd5}, {5'd5, 5'd5}, 2'b11,
                 {32'hBBBB, 32'hAAAA}, 1'b0, '0, 2'b00, 5'd0, 1'b0, 1'b0,
                 {2'd0, 2'd1}, {32'h0, 32'hAAAA}, 1'b0};
    vecs[1]  = '{"fwd_rd_zero", {5'd0, 5'd0}, {5'd0, 5'd0}, 2'b11,
                 {32'hBBBB, 32'hAAAA}, 1'b0, '0, 2'b00, 5'd0, 1'b0, 1'b0,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b0};
    vecs[2]  = '{"fwd_oldest_only", {5'd6, 5'd6}, {5'd6, 5'd6}, 2'b10,
                 {32'h1234, 32'h5678}, 1'b0, '0, 2'b00, 5'd0, 1'b0, 1'b0,
                 {2'd2, 2'd2}, {32'h1234, 32'h1234}, 1'b0};
    vecs[3]  = '{"fwd_no_regwrite", {5'd6, 5'd6}, {5'd6, 5'd6}, 2'b00,
                 {32'h1234, 32'h5678}, 1'b0, '0, 2'b00, 5'd0, 1'b0, 1'b0,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b0};
    vecs[4]  = '{"fwd_split", {5'd8, 5'd3}, {5'd8, 5'd3}, 2'b11,
                 {32'hD1D1_0001, 32'hD0D0_0000}, 1'b0, '0, 2'b00, 5'd0, 1'b0, 1'b0,
                 {2'd2, 2'd1}, {32'hD1D1_0001, 32'hD0D0_0000}, 1'b0};
    vecs[5]  = '{"lu_hit", {5'd0, 5'd0}, '0, 2'b00, '0,
                 1'b1, {5'd7, 5'd0}, 2'b10, 5'd7, 1'b1, 1'b1,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b1};
    vecs[6]  = '{"lu_unused", {5'd0, 5'd0}, '0, 2'b00, '0,
                 1'b1, {5'd7, 5'd0}, 2'b00, 5'd7, 1'b1, 1'b1,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b0};
    vecs[7]  = '{"lu_other_src", {5'd0, 5'd0}, '0, 2'b00, '0,
                 1'b1, {5'd7, 5'd2}, 2'b01, 5'd7, 1'b1, 1'b1,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b0};
    vecs[8]  = '{"lu_x0", {5'd0, 5'd0}, '0, 2'b00, '0,
                 1'b1, {5'd0, 5'd0}, 2'b11, 5'd0, 1'b1, 1'b1,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b0};
    vecs[9]  = '{"lu_not_load", {5'd0, 5'd0}, '0, 2'b00, '0,
                 1'b1, {5'd7, 5'd0}, 2'b10, 5'd7, 1'b1, 1'b0,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b0};
    vecs[10] = '{"lu_id_invalid", {5'd0, 5'd0}, '0, 2'b00, '0,
                 1'b0, {5'd7, 5'd0}, 2'b10, 5'd7, 1'b1, 1'b1,
                 {2'd0, 2'd0}, {32'h0, 32'h0}, 1'b0};

    // ---- reset state --------------------------------------------------------
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sample();
    check("reset_sb_busy", 64'(sb_busy), 64'h0);
    check("reset_timeout", 64'(stall_timeout), 64'h0);
    check("reset_stall", 64'(stall_id), 64'h0);
    check("reset_bubble", 64'(bubble_ex), 64'h0);
    check("reset_fwd_sel", 64'(fwd_sel), 64'h0);

    // ---- table-driven combinational vectors --------------------------------
    for (int i = 0; i < 11; i++) begin
      tick();
      clear_inputs();
      ex_rs_addr    = vecs[i].ex_rs;
      fwd_rd_addr   = vecs[i].f_rd;
      fwd_reg_write = vecs[i].f_rw;
      fwd_data      = vecs[i].f_data;
      id_valid      = vecs[i].idv;
      id_rs_addr    = vecs[i].id_rs;
      id_rs_used    = vecs[i].used;
      ex_rd_addr    = vecs[i].ex_rd;
      ex_reg_write  = vecs[i].ex_rw;
      ex_is_load    = vecs[i].ex_ld;
      sample();
      check({vecs[i].name, "_sel"},    64'(fwd_sel),   64'(vecs[i].exp_sel));
      check({vecs[i].name, "_val"},    fwd_val,        vecs[i].exp_val);
      check({vecs[i].name, "_stall"},  64'(stall_id),  64'(vecs[i].exp_stall));
      check({vecs[i].name, "_bubble"}, 64'(bubble_ex), 64'(vecs[i].exp_stall));
    end

    // ---- scoreboard: issue to x9, read x9 until writeback ------------------
    tick();
    clear_inputs();
    id_valid    = 1'b1;
    id_mc_issue = 1'b1;
    id_rd_addr  = 5'd9;
    sample();
    check("sb_issue_no_stall", 64'(stall_id), 64'h0);
    tick();
    id_mc_issue = 1'b0;
    id_rd_addr  = 5'd0;
    id_rs_addr  = {5'd0, 5'd9};
    id_rs_used  = 2'b01;
    sample();
    check("sb_busy9_set", 64'(sb_busy), 64'h200);
    check("sb_read_stall", 64'(stall_id), 64'h1);
    for (int c = 0; c < 3; c++) begin
      tick();
      sample();
      check("sb_stall_hold", 64'(stall_id), 64'h1);
    end
    tick();
    mc_wb_valid   = 1'b1;
    mc_wb_rd_addr = 5'd9;
    sample();
    check("sb_wb_cycle_still_stall", 64'(stall_id), 64'h1);
    tick();
    mc_wb_valid = 1'b0;
    sample();
    check("sb_busy9_cleared", 64'(sb_busy), 64'h0);
    check("sb_stall_dropped", 64'(stall_id), 64'h0);

    // ---- x0 is never marked busy -------------------------------------------
    tick();
    clear_inputs();
    id_valid    = 1'b1;
    id_mc_issue = 1'b1;
    id_rd_addr  = 5'd0;
    tick();
    clear_inputs();
    sample();
    check("sb_x0_never_set", 64'(sb_busy), 64'h0);

    // ---- same-cycle set and clear of x3: set wins --------------------------
    id_valid      = 1'b1;
    id_mc_issue   = 1'b1;
    id_rd_addr    = 5'd3;
    mc_wb_valid   = 1'b1;
    mc_wb_rd_addr = 5'd3;
    tick();
    clear_inputs();
    sample();
    check("sb_set_wins", 64'(sb_busy), 64'h8);
    // WAW: a new writer of x3 must wait.
    id_valid   = 1'b1;
    id_rd_addr = 5'd3;
    sample();
    check("sb_waw_stall", 64'(stall_id), 64'h1);
    tick();
    clear_inputs();
    mc_wb_valid   = 1'b1;
    mc_wb_rd_addr = 5'd3;
    tick();
    clear_inputs();
    // Clearing a register that is not busy changes nothing.
    mc_wb_valid   = 1'b1;
    mc_wb_rd_addr = 5'd12;
    tick();
    clear_inputs();
    sample();
    check("sb_x3_cleared", 64'(sb_busy), 64'h0);

    // ---- stall watchdog -----------------------------------------------------
    id_valid    = 1'b1;
    id_mc_issue = 1'b1;
    id_rd_addr  = 5'd4;
    tick();
    clear_inputs();
    id_valid   = 1'b1;
    id_rs_addr = {5'd4, 5'd0};
    id_rs_used = 2'b10;
    sample();
    check("wd_stall_start", 64'(stall_id), 64'h1);
    for (int c = 1; c <= 15; c++) begin
      tick();
      sample();
      if (c == 14) check("wd_timeout_before", 64'(stall_timeout), 64'h0);
      if (c == 15) check("wd_timeout_at_15", 64'(stall_timeout), 64'h1);
    end
    mc_wb_valid   = 1'b1;
    mc_wb_rd_addr = 5'd4;
    tick();
    mc_wb_valid = 1'b0;
    sample();
    check("wd_stall_cleared", 64'(stall_id), 64'h0);
    check("wd_timeout_sticky", 64'(stall_timeout), 64'h1);
    tick();
    sample();
    check("wd_timeout_sticky2", 64'(stall_timeout), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check("wd_rst_timeout", 64'(stall_timeout), 64'h0);
    check("wd_rst_sb", 64'(sb_busy), 64'h0);

    // ---- reset mid-operation -----------------------------------------------
    clear_inputs();
    id_valid    = 1'b1;
    id_mc_issue = 1'b1;
    id_rd_addr  = 5'd9;
    tick();
    id_rd_addr = 5'd10;
    tick();
    clear_inputs();
    sample();
    check("rmid_busy_0600", 64'(sb_busy), 64'h600);
    id_valid   = 1'b1;
    id_rs_addr = {5'd0, 5'd9};
    id_rs_used = 2'b01;
    sample();
    check("rmid_stall_before", 64'(stall_id), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check("rmid_sb_cleared", 64'(sb_busy), 64'h0);
    check("rmid_no_stall", 64'(stall_id), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
